// File: rtl/mod_delay_line.sv
// mod_delay_line
//   Modulated-delay effect stage (bypass / vibrato / chorus). A triangle LFO
//   moves a fractional read position behind the newest sample. The two SRAM
//   words around that position are read and linearly interpolated. Chorus
//   additionally reads the newest (dry) sample and averages it with the wet tap.
//   One sample operation runs per granted slot (my_turn), ending in a done pulse.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   cs                block enable; 0 passes the slot straight to done
//   my_turn           slot grant (level), starts an operation when idle
//   done              1-cycle pulse, data_out valid from this cycle
//   mode              0/3 bypass, 1 vibrato, 2 chorus
//   phase_inc         LFO phase step per processed sample
//   depth, base_delay modulation depth / centre delay, unsigned fixed point
//   sram_rd           read request, held until sram_read_finish
//   sram_offset       read offset in samples back from newest
//   sram_data_in      read data, valid with sram_read_finish
//   data_out          processed sample
module mod_delay_line #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int FRAC_W  = 8,
    parameter int PHASE_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     my_turn,
    output logic                     done,
    input  logic [1:0]               mode,
    input  logic [PHASE_W-1:0]       phase_inc,
    input  logic [ADDR_W+FRAC_W-1:0] depth,
    input  logic [ADDR_W+FRAC_W-1:0] base_delay,
    output logic                     sram_rd,
    output logic [ADDR_W-1:0]        sram_offset,
    input  logic [DATA_W-1:0]        sram_data_in,
    input  logic                     sram_read_finish,
    output logic [DATA_W-1:0]        data_out
);

    localparam int DLY_W  = ADDR_W + FRAC_W;
    localparam int TRI_W  = 16;
    localparam int PROD_W = DLY_W + TRI_W;
    localparam int MIX_W  = DATA_W + FRAC_W + 2;

    // Largest integer delay: 2^ADDR_W-2, so that the second tap D+1 still fits.
    localparam logic [ADDR_W:0]   MAX_INT_C  = {1'b0, {(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] ONE_OFF_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        MODE_VIB_C = 2'd1;
    localparam logic [1:0]        MODE_CHO_C = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_RD0  = 3'd2,
        ST_RD1  = 3'd3,
        ST_RDD  = 3'd4,
        ST_MIX  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t state_r, state_s;

    logic [1:0]         mode_r;
    logic [PHASE_W-1:0] inc_r;
    logic [DLY_W-1:0]   depth_r;
    logic [DLY_W-1:0]   base_r;
    logic [PHASE_W-1:0] phase_r;
    logic [ADDR_W-1:0]  d_r;
    logic [FRAC_W-1:0]  f_r;
    logic [DATA_W-1:0]  s0_r, s1_r, dry_r;
    logic               sram_rd_r;
    logic [ADDR_W-1:0]  sram_offset_r;
    logic [DATA_W-1:0]  data_out_r;
    logic               done_r;

    logic                     bypass_s;
    logic                     rd_done_s;
    logic [ADDR_W-1:0]        rd_off_s;
    logic [PHASE_W-2:0]       fold_s;
    logic [TRI_W-1:0]         tri_s;
    logic [PROD_W-1:0]        prod_s;
    logic [DLY_W-1:0]         mod_s;
    logic [DLY_W:0]           sum_s;
    logic [ADDR_W:0]          int_s;
    logic [ADDR_W-1:0]        d_calc_s;
    logic [FRAC_W-1:0]        f_calc_s;
    logic signed [DATA_W:0]   s0_x_s, s1_x_s, dry_x_s, diff_s, step_s, wet_s, cho_sum_s;
    logic signed [MIX_W-1:0]  prod_mix_s, shift_s;
    logic [DATA_W-1:0]        mix_s;
    logic                     unused_bits_s;

    assign bypass_s  = (mode_r != MODE_VIB_C) && (mode_r != MODE_CHO_C);
    assign rd_done_s = sram_rd_r && sram_read_finish;

    assign done        = done_r;
    assign sram_rd     = sram_rd_r;
    assign sram_offset = sram_offset_r;
    assign data_out    = data_out_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection for the sample operation sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (my_turn) begin
                    if (cs) state_s = ST_CALC;
                    else    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bypass_s) state_s = ST_RDD;
                else          state_s = ST_RD0;
            end
            ST_RD0: begin
                if (rd_done_s) state_s = ST_RD1;
                else           state_s = ST_RD0;
            end
            ST_RD1: begin
                if (rd_done_s) begin
                    if (mode_r == MODE_CHO_C) state_s = ST_RDD;
                    else                      state_s = ST_MIX;
                end else begin
                    state_s = ST_RD1;
                end
            end
            ST_RDD: begin
                if (rd_done_s) state_s = ST_MIX;
                else           state_s = ST_RDD;
            end
            ST_MIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Offset requested by the current read state (dry tap is the newest sample).
    always_comb begin
        rd_off_s = {ADDR_W{1'b0}};
        case (state_r)
            ST_RD0:  rd_off_s = d_r;
            ST_RD1:  rd_off_s = d_r + ONE_OFF_C;
            default: rd_off_s = {ADDR_W{1'b0}};
        endcase
    end

    // Triangle LFO to fractional delay, with integer part clamped to the last usable tap pair.
    always_comb begin
        fold_s = phase_r[PHASE_W-1] ? ~phase_r[PHASE_W-2:0] : phase_r[PHASE_W-2:0];
        tri_s  = fold_s[PHASE_W-2 -: TRI_W];
        prod_s = PROD_W'(depth_r) * PROD_W'(tri_s);
        mod_s  = prod_s[PROD_W-1:TRI_W];
        sum_s  = {1'b0, base_r} + {1'b0, mod_s};
        int_s  = sum_s[DLY_W:FRAC_W];
        if (int_s > MAX_INT_C) begin
            d_calc_s = MAX_INT_C[ADDR_W-1:0];
            f_calc_s = {FRAC_W{1'b0}};
        end else begin
            d_calc_s = int_s[ADDR_W-1:0];
            f_calc_s = sum_s[FRAC_W-1:0];
        end
    end

    // Linear interpolation between the two taps and the per-mode output mix.
    // One extra bit of headroom covers s1-s0; the interpolated value itself
    // always lies between s0 and s1, so its top bit is only a sign copy.
    always_comb begin
        s0_x_s     = {s0_r[DATA_W-1], s0_r};
        s1_x_s     = {s1_r[DATA_W-1], s1_r};
        dry_x_s    = {dry_r[DATA_W-1], dry_r};
        diff_s     = s1_x_s - s0_x_s;
        prod_mix_s = MIX_W'(diff_s) * MIX_W'($signed({1'b0, f_r}));
        shift_s    = prod_mix_s >>> FRAC_W;
        step_s     = shift_s[DATA_W:0];
        wet_s      = s0_x_s + step_s;
        cho_sum_s  = dry_x_s + wet_s;
        case (mode_r)
            MODE_VIB_C: mix_s = wet_s[DATA_W-1:0];
            MODE_CHO_C: mix_s = cho_sum_s[DATA_W:1];
            default:    mix_s = dry_r;
        endcase
    end

    assign unused_bits_s = ^{fold_s, prod_s[TRI_W-1:0], shift_s, wet_s[DATA_W], cho_sum_s[0]};

    // Operation parameters, LFO phase, read handshake, captured taps and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r        <= 2'd0;
            inc_r         <= {PHASE_W{1'b0}};
            depth_r       <= {DLY_W{1'b0}};
            base_r        <= {DLY_W{1'b0}};
            phase_r       <= {PHASE_W{1'b0}};
            d_r           <= {ADDR_W{1'b0}};
            f_r           <= {FRAC_W{1'b0}};
            s0_r          <= {DATA_W{1'b0}};
            s1_r          <= {DATA_W{1'b0}};
            dry_r         <= {DATA_W{1'b0}};
            sram_rd_r     <= 1'b0;
            sram_offset_r <= {ADDR_W{1'b0}};
            data_out_r    <= {DATA_W{1'b0}};
            done_r        <= 1'b0;
        end else begin
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (my_turn && cs) begin
                        mode_r  <= mode;
                        inc_r   <= phase_inc;
                        depth_r <= depth;
                        base_r  <= base_delay;
                    end
                end
                ST_CALC: begin
                    d_r     <= d_calc_s;
                    f_r     <= f_calc_s;
                    phase_r <= phase_r + inc_r;
                end
                ST_RD0, ST_RD1, ST_RDD: begin
                    // Each read state enters with sram_rd low, which gives the
                    // mandatory idle cycle between consecutive requests.
                    if (!sram_rd_r) begin
                        sram_rd_r     <= 1'b1;
                        sram_offset_r <= rd_off_s;
                    end else if (sram_read_finish) begin
                        sram_rd_r <= 1'b0;
                        case (state_r)
                            ST_RD0:  s0_r  <= sram_data_in;
                            ST_RD1:  s1_r  <= sram_data_in;
                            default: dry_r <= sram_data_in;
                        endcase
                    end
                end
                ST_MIX:  data_out_r <= mix_s;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_delay_line.sv
module tb_mod_delay_line;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 13;
    localparam int FRAC_W  = 8;
    localparam int PHASE_W = 24;
    localparam int DW      = ADDR_W + FRAC_W;

    logic                clk = 1'b0;
    logic                rst, cs, my_turn, done, sram_rd, sram_read_finish;
    logic [1:0]          mode;
    logic [PHASE_W-1:0]  phase_inc;
    logic [DW-1:0]       depth, base_delay;
    logic [ADDR_W-1:0]   sram_offset;
    logic [DATA_W-1:0]   sram_data_in, data_out;

    always #5 clk = ~clk;

    mod_delay_line #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .done(done), .mode(mode),
        .phase_inc(phase_inc), .depth(depth), .base_delay(base_delay),
        .sram_rd(sram_rd), .sram_offset(sram_offset), .sram_data_in(sram_data_in),
        .sram_read_finish(sram_read_finish), .data_out(data_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pattern = 0;
    int rd_cnt = 0;
    int unsigned rd_log[$];
    logic [ADDR_W-1:0] off_first;
    logic [PHASE_W-1:0] m_phase;
    logic [DATA_W-1:0]  m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // SRAM content: pattern 0 is word(k)=4*k, pattern 1 a signed pseudo-random word.
    function automatic logic [DATA_W-1:0] word_at(input int pat, input int k);
        logic [31:0] h;
        h = 32'(k) * 32'd40503 + 32'd12345;
        h = h ^ (h >> 11);
        if (pat == 0) return DATA_W'(4 * k);
        return h[23:8];
    endfunction

    function automatic longint sval(input longint k);
        return longint'($signed(word_at(pattern, int'(k))));
    endfunction

    // SRAM responder: read_finish 3 cycles after sram_rd rises, offset must not move.
    always @(negedge clk) begin
        if (sram_rd === 1'b1 && !sram_read_finish) begin
            if (rd_cnt == 0) off_first = sram_offset;
            if (rd_cnt == 2) begin
                check("offset_stable", 32'(sram_offset), 32'(off_first));
                sram_read_finish = 1'b1;
                sram_data_in     = word_at(pattern, int'(sram_offset));
                rd_log.push_back(int'(sram_offset));
            end
            rd_cnt++;
        end else begin
            sram_read_finish = 1'b0;
            rd_cnt = 0;
        end
    end

    // Reference: effect computed directly from the arithmetic definition.
    function automatic void ref_model(input logic [1:0] md, input logic [PHASE_W-1:0] ph,
                                      input logic [DW-1:0] dep, input logic [DW-1:0] bas,
                                      output logic [DATA_W-1:0] y, output int nrd, output int off0);
        longint half, full, p, fold, tri_v, mv, dly, d, f, maxd, s0, s1, dry, wet;
        half = longint'(1) << (PHASE_W - 1);
        full = longint'(1) << PHASE_W;
        p    = longint'(ph);
        fold = (p >= half) ? (full - 1 - p) : p;
        tri_v = fold >> (PHASE_W - 1 - 16);
        mv   = (longint'(dep) * tri_v) >> 16;
        dly  = longint'(bas) + mv;
        d    = dly >> FRAC_W;
        f    = dly % (longint'(1) << FRAC_W);
        maxd = (longint'(1) << ADDR_W) - 2;
        if (d > maxd) begin
            d = maxd;
            f = 0;
        end
        s0  = sval(d);
        s1  = sval(d + 1);
        dry = sval(0);
        wet = s0 + (((s1 - s0) * f) >>> FRAC_W);
        case (md)
            2'd1:    begin y = DATA_W'(wet);               nrd = 2; off0 = int'(d); end
            2'd2:    begin y = DATA_W'((dry + wet) >>> 1); nrd = 3; off0 = int'(d); end
            default: begin y = DATA_W'(dry);               nrd = 1; off0 = 0;       end
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_phase = '0;
        m_last  = '0;
    endtask

    task automatic run_and_check(input string name, input logic c, input logic [1:0] md,
                                 input logic [PHASE_W-1:0] inc, input logic [DW-1:0] dep,
                                 input logic [DW-1:0] bas, input logic [DATA_W-1:0] exp_y,
                                 input int exp_nrd, input int exp_off0);
        int ndone, ncyc, eo;
        logic [DATA_W-1:0] y;
        rd_log.delete();
        @(posedge clk); #1;
        cs = c; mode = md; phase_inc = inc; depth = dep; base_delay = bas; my_turn = 1'b1;
        @(posedge clk); #1;
        my_turn = 1'b0;
        ndone = 0; ncyc = 1; y = '0;
        for (int i = 0; i < 200 && ndone == 0; i++) begin
            @(negedge clk);
            ncyc++;
            if (done) begin
                ndone = 1;
                y = data_out;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check({name, "_done_pulses"}, 32'(ndone), 32'd1);
        check({name, "_data_out"}, 32'(y), 32'(exp_y));
        check({name, "_nreads"}, 32'(rd_log.size()), 32'(exp_nrd));
        for (int i = 0; i < rd_log.size() && i < exp_nrd; i++) begin
            eo = (exp_nrd == 1 || i == 2) ? 0 : exp_off0 + i;
            check($sformatf("%s_off%0d", name, i), 32'(rd_log[i]), 32'(eo));
        end
        if (!c) check({name, "_latency"}, 32'(ncyc), 32'd2);
    endtask

    typedef struct {
        logic               c;
        logic [1:0]         md;
        logic [PHASE_W-1:0] inc;
        logic [DW-1:0]      dep;
        logic [DW-1:0]      bas;
        logic [DATA_W-1:0]  y;
        int                 nrd;
        int                 off0;
    } vec_t;

    initial begin
        vec_t tbl[13];
        logic [DATA_W-1:0] held_exp[5];
        logic [DATA_W-1:0] ey;
        int enr, eo, got, long_pulse;
        logic prev_done, c;
        logic [1:0] md;
        logic [PHASE_W-1:0] inc;
        logic [DW-1:0] dep, bas;

        // Integer and fractional taps, chorus, bypass, LFO sweep, saturation, cs=0.
        tbl[0]  = '{1'b1, 2'd1, 24'h0,      21'h0,      21'hA00,     16'd40,    2, 10};
        tbl[1]  = '{1'b1, 2'd1, 24'h0,      21'h0,      21'hA80,     16'd42,    2, 10};
        tbl[2]  = '{1'b1, 2'd1, 24'h0,      21'h0,      21'hA40,     16'd41,    2, 10};
        tbl[3]  = '{1'b1, 2'd2, 24'h0,      21'h0,      21'hA00,     16'd20,    3, 10};
        tbl[4]  = '{1'b1, 2'd0, 24'h0,      21'h0,      21'hA00,     16'd0,     1, 0};
        tbl[5]  = '{1'b1, 2'd3, 24'h0,      21'h0,      21'hA00,     16'd0,     1, 0};
        tbl[6]  = '{1'b1, 2'd1, 24'h400000, 21'h400,    21'hA00,     16'd40,    2, 10};
        tbl[7]  = '{1'b1, 2'd1, 24'h400000, 21'h400,    21'hA00,     16'd48,    2, 12};
        tbl[8]  = '{1'b1, 2'd1, 24'h400000, 21'h400,    21'hA00,     16'd55,    2, 13};
        // Phase 0xC00000 folds to 0x3FFFFF (just below midscale): delay 0xBFF -> 44 + 3.
        tbl[9]  = '{1'b1, 2'd1, 24'h400000, 21'h400,    21'hA00,     16'd47,    2, 11};
        tbl[10] = '{1'b1, 2'd1, 24'h400000, 21'h400,    21'hA00,     16'd40,    2, 10};
        tbl[11] = '{1'b1, 2'd1, 24'h0,      21'h1FFFFF, 21'h1FFFFF,  16'd32760, 2, 8190};
        tbl[12] = '{1'b0, 2'd1, 24'h0,      21'h0,      21'hA00,     16'd32760, 0, 0};
        held_exp[0] = 16'd40; held_exp[1] = 16'd48; held_exp[2] = 16'd55;
        held_exp[3] = 16'd47; held_exp[4] = 16'd40;

        rst = 1'b1; cs = 1'b0; my_turn = 1'b0; mode = 2'd0; phase_inc = '0;
        depth = '0; base_delay = '0; sram_read_finish = 1'b0; sram_data_in = '0;
        m_phase = '0; m_last = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sram_rd", 32'(sram_rd), 32'd0);
        check("reset_offset", 32'(sram_offset), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);

        pattern = 0;
        for (int i = 0; i < 13; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].c, tbl[i].md, tbl[i].inc, tbl[i].dep,
                          tbl[i].bas, tbl[i].y, tbl[i].nrd, tbl[i].off0);

        // my_turn held high: back-to-back operations sweep the LFO.
        do_reset();
        cs = 1'b1; mode = 2'd1; phase_inc = 24'h400000; depth = 21'h400; base_delay = 21'hA00;
        @(posedge clk); #1;
        my_turn = 1'b1;
        got = 0; prev_done = 1'b0; long_pulse = 0;
        for (int i = 0; i < 400 && got < 5; i++) begin
            @(negedge clk);
            if (done && prev_done) long_pulse++;
            prev_done = done;
            if (done) begin
                check($sformatf("held_out%0d", got), 32'(data_out), 32'(held_exp[got]));
                got++;
                if (got == 5) my_turn = 1'b0;
            end
        end
        check("held_count", 32'(got), 32'd5);
        check("held_long_pulse", 32'(long_pulse), 32'd0);
        repeat (4) @(negedge clk);

        // Reset while waiting on the second read aborts; phase restarts at 0.
        rd_log.delete();
        @(posedge clk); #1;
        my_turn = 1'b1;
        @(posedge clk); #1;
        my_turn = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (sram_rd && rd_log.size() == 1) got = 1;
        end
        check("reached_rd1", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sram_rd", 32'(sram_rd), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        m_phase = '0; m_last = '0;
        run_and_check("rerun", 1'b1, 2'd1, 24'h0, 21'h400, 21'hA00, 16'd40, 2, 10);

        // Randomized operations against the reference model.
        do_reset();
        pattern = 1;
        for (int n = 0; n < 80; n++) begin
            c   = ($urandom_range(0, 7) != 0);
            md  = 2'($urandom_range(0, 3));
            inc = PHASE_W'($urandom);
            dep = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 4095));
            bas = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 500000));
            if (c) begin
                ref_model(md, m_phase, dep, bas, ey, enr, eo);
                m_phase = m_phase + inc;
                m_last  = ey;
            end else begin
                ey = m_last; enr = 0; eo = 0;
            end
            run_and_check($sformatf("rand%0d", n), c, md, inc, dep, bas, ey, enr, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
